// File: rtl/cache_arbiter.sv
// cache_arbiter
//   Shares one cacheline adaptor between an I-cache and a D-cache.
//   Ownership is granted from IDLE, held in SERVE_I/SERVE_D until the
//   adaptor responds, then a one-cycle RELEASE deasserts every pmem_*
//   request so the adaptor always sees a gap between transactions.
//
//   Optional feature macro: ARBITER_ROUND_ROBIN_EN
//     defined   -> simultaneous requests alternate away from last_grant
//     undefined -> simultaneous requests always go to the D-cache
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   i_pmem_read/address         I-cache fill request
//   i_pmem_rdata/resp           I-cache fill data / completion
//   d_pmem_read/write/address   D-cache fill / writeback request
//   d_pmem_wdata                D-cache writeback data
//   d_pmem_rdata/resp           D-cache fill data / completion
//   pmem_read/write/address/wdata   request to cacheline adaptor
//   pmem_rdata/resp                 response from cacheline adaptor
module cache_arbiter #(
    parameter int s_line = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pmem_read,
    input  logic [31:0]       i_pmem_address,
    output logic [s_line-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [31:0]       d_pmem_address,
    input  logic [s_line-1:0] d_pmem_wdata,
    output logic [s_line-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [31:0]       pmem_address,
    output logic [s_line-1:0] pmem_wdata,
    input  logic [s_line-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RELEASE} state_t;

    state_t state, state_next;
    logic   last_grant, last_grant_next;   // 0 = I, 1 = D
    logic   i_req, d_req, pick_d;

    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;

    // Tie-break for simultaneous requests. last_grant resets to I, so the
    // first contested grant after reset goes to D in both modes.
`ifdef ARBITER_ROUND_ROBIN_EN
    assign pick_d = ~last_grant;
`else
    assign pick_d = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b0;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
        end
    end

    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        case (state)
            IDLE: begin
                if (d_req && (!i_req || pick_d)) begin
                    state_next      = SERVE_D;
                    last_grant_next = 1'b1;
                end else if (i_req) begin
                    state_next      = SERVE_I;
                    last_grant_next = 1'b0;
                end
            end
            // Owner dropping its request does not end the transaction;
            // only the adaptor response does.
            SERVE_I, SERVE_D: if (pmem_resp) state_next = RELEASE;
            RELEASE:          state_next = IDLE;
            default:          state_next = IDLE;
        endcase
    end

    // Outputs are forced quiet while rst is high so an abandoned
    // transaction is dropped in the reset cycle itself, not one later.
    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        i_pmem_resp  = 1'b0;
        i_pmem_rdata = '0;
        d_pmem_resp  = 1'b0;
        d_pmem_rdata = '0;
        if (!rst) begin
            case (state)
                SERVE_I: begin
                    pmem_read    = i_pmem_read;
                    pmem_address = i_pmem_address;
                    i_pmem_resp  = pmem_resp;
                    i_pmem_rdata = pmem_rdata;
                end
                SERVE_D: begin
                    // Writeback wins when both read and write are raised.
                    pmem_read    = d_pmem_read & ~d_pmem_write;
                    pmem_write   = d_pmem_write;
                    pmem_address = d_pmem_address;
                    pmem_wdata   = d_pmem_wdata;
                    d_pmem_resp  = pmem_resp;
                    d_pmem_rdata = pmem_rdata;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_arbiter.sv
module tb_cache_arbiter;

    localparam int SL = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_pmem_read = 1'b0;
    logic [31:0]   i_pmem_address = '0;
    logic [SL-1:0] i_pmem_rdata;
    logic          i_pmem_resp;
    logic          d_pmem_read = 1'b0;
    logic          d_pmem_write = 1'b0;
    logic [31:0]   d_pmem_address = '0;
    logic [SL-1:0] d_pmem_wdata = '0;
    logic [SL-1:0] d_pmem_rdata;
    logic          d_pmem_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [31:0]   pmem_address;
    logic [SL-1:0] pmem_wdata;
    logic [SL-1:0] pmem_rdata = '0;
    logic          pmem_resp = 1'b0;

    cache_arbiter #(.s_line(SL)) dut (
        .clk(clk), .rst(rst),
        .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
        .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rd;
        logic          wr;
        logic [31:0]   addr;
        logic [SL-1:0] wdata;
    } req_t;

    typedef struct {
        logic          side;   // 0 = I, 1 = D
        logic [SL-1:0] rdata;
    } rsp_t;

    req_t exp_req[$];
    rsp_t exp_rsp[$];

    int checks = 0;
    int errors = 0;

    // adaptor model controls
    logic          adp_en = 1'b1;
    int            adp_lat = 4;
    logic [SL-1:0] adp_rdata = '0;

    task automatic chk(input string name, input logic [SL-1:0] act, input logic [SL-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event not expected or not seen", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input logic rd, input logic wr, input logic [31:0] a, input logic [SL-1:0] w);
        req_t r;
        r.rd = rd; r.wr = wr; r.addr = a; r.wdata = w;
        exp_req.push_back(r);
    endtask

    task automatic push_rsp(input logic side, input logic [SL-1:0] d);
        rsp_t r;
        r.side = side; r.rdata = d;
        exp_rsp.push_back(r);
    endtask

    // returns at the negedge where a cache-side resp is visible
    task automatic wait_resp(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(i_pmem_resp || d_pmem_resp) && n < 50);
        if (!(i_pmem_resp || d_pmem_resp)) fail({name, "_timeout"});
    endtask

    task automatic chk_quiet(input string name);
        chk({name, "_pmem_read"},  pmem_read, 0);
        chk({name, "_pmem_write"}, pmem_write, 0);
        chk({name, "_pmem_addr"},  pmem_address, 0);
        chk({name, "_pmem_wdata"}, pmem_wdata, 0);
        chk({name, "_i_resp"},     i_pmem_resp, 0);
        chk({name, "_d_resp"},     d_pmem_resp, 0);
        chk({name, "_i_rdata"},    i_pmem_rdata, 0);
        chk({name, "_d_rdata"},    d_pmem_rdata, 0);
    endtask

    // Adaptor model: responds adp_lat cycles into a request, one-cycle resp.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk);
            #2;
            if (adp_en) begin
                if (pmem_resp) begin
                    pmem_resp  = 1'b0;
                    pmem_rdata = '0;
                    cnt = 0;
                end else if (pmem_read || pmem_write) begin
                    cnt++;
                    if (cnt >= adp_lat) begin
                        pmem_resp  = 1'b1;
                        pmem_rdata = adp_rdata;
                    end
                end else begin
                    cnt = 0;
                end
            end
        end
    end

    // Monitor: compares each new adaptor request and each cache response
    // against the scoreboard queues.
    initial begin
        logic prev_act, act;
        req_t q;
        rsp_t s;
        prev_act = 1'b0;
        forever begin
            @(negedge clk);
            act = pmem_read | pmem_write;
            if (act && !prev_act) begin
                if (exp_req.size() == 0) fail("unexpected_pmem_req");
                else begin
                    q = exp_req.pop_front();
                    chk("req_read",  pmem_read,    q.rd);
                    chk("req_write", pmem_write,   q.wr);
                    chk("req_addr",  pmem_address, q.addr);
                    chk("req_wdata", pmem_wdata,   q.wdata);
                end
            end
            prev_act = act;
            if (i_pmem_resp || d_pmem_resp) begin
                if (exp_rsp.size() == 0) fail("unexpected_resp");
                else begin
                    s = exp_rsp.pop_front();
                    chk("rsp_i",     i_pmem_resp, !s.side);
                    chk("rsp_d",     d_pmem_resp, s.side);
                    chk("rsp_rdata", s.side ? d_pmem_rdata : i_pmem_rdata, s.rdata);
                    chk("rsp_other_rdata", s.side ? i_pmem_rdata : d_pmem_rdata, 0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [SL-1:0] w;
        // reset state
        @(negedge clk); chk_quiet("reset_during");
        tick(); rst = 1'b0;
        @(negedge clk); chk_quiet("reset_after");

        // I-only read, one-cycle request latency, 4-cycle adaptor latency
        tick();
        adp_lat = 4; adp_rdata = {32{8'hA5}};
        i_pmem_address = 32'h0000_1000; i_pmem_read = 1'b1;
        push_req(1, 0, 32'h0000_1000, '0);
        push_rsp(0, {32{8'hA5}});
        @(negedge clk); chk("i_lat_cycle0", pmem_read, 0);
        @(negedge clk); chk("i_lat_cycle1", pmem_read, 1);
        wait_resp("i_read");
        tick(); i_pmem_read = 1'b0;
        @(negedge clk); chk_quiet("release");
        tick();

        // D writeback
        w = {8{32'h1234_5678}};
        adp_rdata = {8{32'hCAFE_0001}};
        d_pmem_address = 32'h0000_2040; d_pmem_wdata = w; d_pmem_write = 1'b1;
        push_req(0, 1, 32'h0000_2040, w);
        push_rsp(1, {8{32'hCAFE_0001}});
        wait_resp("d_write");
        tick(); d_pmem_write = 1'b0;
        tick();

        // D read+write together: write wins
        w = {8{32'hDEAD_BEEF}};
        adp_rdata = {8{32'h0BAD_F00D}};
        d_pmem_address = 32'h0000_3000; d_pmem_wdata = w;
        d_pmem_read = 1'b1; d_pmem_write = 1'b1;
        push_req(0, 1, 32'h0000_3000, w);
        push_rsp(1, {8{32'h0BAD_F00D}});
        wait_resp("d_rw");
        tick(); d_pmem_read = 1'b0; d_pmem_write = 1'b0;
        tick();

        // reset two cycles into SERVE_D, then stray resp in IDLE
        adp_lat = 10;
        d_pmem_address = 32'h0000_6000; d_pmem_wdata = '0; d_pmem_read = 1'b1;
        push_req(1, 0, 32'h0000_6000, '0);
        tick();               // SERVE_D cycle 1
        tick();               // SERVE_D cycle 2
        rst = 1'b1;
        @(negedge clk); chk_quiet("midserve_rst");
        tick(); rst = 1'b0; d_pmem_read = 1'b0;
        @(negedge clk); chk_quiet("post_abort");
        tick();
        adp_en = 1'b0;
        pmem_resp = 1'b1; pmem_rdata = {8{32'h5555_AAAA}};
        @(negedge clk); chk_quiet("stray_resp0");
        @(negedge clk); chk_quiet("stray_resp1");
        tick(); pmem_resp = 1'b0; pmem_rdata = '0; adp_en = 1'b1;
        tick();

        // simultaneous after reset: D first, I rises 2 edges after D's resp edge
        adp_lat = 3; adp_rdata = {8{32'h3333_3333}};
        d_pmem_address = 32'h0000_7000; d_pmem_read = 1'b1;
        i_pmem_address = 32'h0000_8000; i_pmem_read = 1'b1;
        push_req(1, 0, 32'h0000_7000, '0);
        push_rsp(1, {8{32'h3333_3333}});
        push_req(1, 0, 32'h0000_8000, '0);
        push_rsp(0, {8{32'h4444_4444}});
        wait_resp("both_d");
        tick(); d_pmem_read = 1'b0; adp_rdata = {8{32'h4444_4444}};
        @(negedge clk); chk("gap_release", pmem_read, 0);
        @(negedge clk); chk("gap_idle", pmem_read, 0);
        @(negedge clk); chk("i_after_d", pmem_read, 1);
        wait_resp("both_i");
        tick(); i_pmem_read = 1'b0;
        tick();

        // continuous contention for 4 transactions, starting from reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        adp_lat = 2; adp_rdata = {8{32'h7777_0000}};
        d_pmem_address = 32'h0000_9000; d_pmem_read = 1'b1;
        i_pmem_address = 32'h0000_A000; i_pmem_read = 1'b1;
        for (int k = 0; k < 4; k++) begin
`ifdef ARBITER_ROUND_ROBIN_EN
            if (k % 2 == 0) begin
                push_req(1, 0, 32'h0000_9000, '0); push_rsp(1, {8{32'h7777_0000}});
            end else begin
                push_req(1, 0, 32'h0000_A000, '0); push_rsp(0, {8{32'h7777_0000}});
            end
`else
            push_req(1, 0, 32'h0000_9000, '0); push_rsp(1, {8{32'h7777_0000}});
`endif
        end
        for (int k = 0; k < 4; k++) wait_resp("contend");
        tick(); d_pmem_read = 1'b0; i_pmem_read = 1'b0;
        repeat (4) tick();

        chk("req_queue_drained", exp_req.size(), 0);
        chk("rsp_queue_drained", exp_rsp.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 SHALL have parameter: s_line, 256, cacheline width in bits (matches llc_cacheline).
REQ-002 SHALL have port: clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: i_pmem_read  input  1  I-cache line-fill request.
REQ-005 SHALL have port: i_pmem_address  input  32  I-cache line address.
REQ-006 SHALL have port: i_pmem_rdata  output  s_line  fill data to I-cache.
REQ-007 SHALL have port: i_pmem_resp  output  1  I-cache completion.
REQ-008 SHALL have ports: d_pmem_read / d_pmem_write  input  1 each  D-cache fill / writeback request.
REQ-009 SHALL have port: d_pmem_address  input  32  D-cache line address.
REQ-010 SHALL have port: d_pmem_wdata  input  s_line  D-cache writeback data.
REQ-011 SHALL have ports: d_pmem_rdata  output  s_line; d_pmem_resp  output  1.
REQ-012 SHALL have ports to cacheline adaptor: pmem_read, pmem_write  output  1; pmem_address  output  32; pmem_wdata  output  s_line.
REQ-013 SHALL have ports from cacheline adaptor: pmem_rdata  input  s_line; pmem_resp  input  1.

Function
REQ-014 SHALL implement FSM states IDLE, SERVE_I, SERVE_D, RELEASE.
REQ-015 IDLE: all pmem_* outputs 0; any request moves to SERVE_I or SERVE_D next cycle per REQ-020/021.
REQ-016 SERVE_x: pmem_read/write/address/wdata driven combinationally from owner x's inputs; I-side pmem_write and pmem_wdata forced 0.
REQ-017 SERVE_x: pmem_resp and pmem_rdata routed only to owner; non-owner resp=0, rdata=0.
REQ-018 SERVE_x SHALL remain until pmem_resp=1, regardless of owner dropping its request; on pmem_resp go to RELEASE.
REQ-019 RELEASE: all pmem_* outputs 0, both resps 0; one cycle, then IDLE (guarantees adaptor sees request deasserted between transactions).
REQ-020 Single requester in IDLE SHALL be granted; request-to-pmem_read/write latency exactly 1 cycle.
REQ-021 Simultaneous I and D requests in IDLE resolved per Configuration; loser stays pending, granted earliest in IDLE after RELEASE (min 2 cycles after winner's resp).
REQ-022 d_pmem_read and d_pmem_write both 1: pmem_write=1, pmem_read=0 (write precedence).
REQ-023 last_grant register (1 bit, 0=I, 1=D) SHALL update on every transition into SERVE_x.
REQ-024 pmem_resp outside SERVE_x SHALL be ignored, no state change, no resp forwarded.

Reset
REQ-025 rst SHALL force state=IDLE, last_grant=0 (I) on next edge, overriding all other transitions.
REQ-026 During and after reset cycle: pmem_read=pmem_write=0, pmem_address=0, pmem_wdata=0, i/d_pmem_resp=0, i/d_pmem_rdata=0.
REQ-027 Reset mid-SERVE SHALL abandon the transaction; no resp issued for it.

Configuration
REQ-028 Macro ARBITER_ROUND_ROBIN_EN defined: simultaneous requests granted to side != last_grant (alternates).
REQ-029 Macro undefined: simultaneous requests always granted to D-cache (fixed priority); last_grant still maintained.
REQ-030 Both modes: first simultaneous request after reset granted to D.

Verification
REQ-031 I-only read 0x0000_1000, adaptor resp after 4 cycles with rdata=0xA5..A5 -> pmem_read=1 from cycle 1, i_pmem_resp=1 with that rdata for 1 cycle, d_pmem_resp=0 throughout, RELEASE then IDLE.
REQ-032 D write 0x0000_2040, wdata=0x1234..., -> pmem_write=1, pmem_address=0x0000_2040, pmem_wdata matches, d_pmem_resp on adaptor resp.
REQ-033 I and D request same cycle after reset, held -> D served first, then I; pmem_read for I rises exactly 2 cycles after D's resp.
REQ-034 Both requesters continuously asserting for 4 transactions -> macro defined: D,I,D,I; undefined: D,D,D,D.
REQ-035 rst asserted 2 cycles into SERVE_D -> next cycle all outputs 0, state IDLE, no d_pmem_resp; stray pmem_resp in IDLE ignored.
REQ-036 d_pmem_read=d_pmem_write=1 at 0x0000_3000 -> pmem_write=1, pmem_read=0.
